// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LD
    } grant_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: issue sets a bit, the driven register write clears it.
module wb_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]   busy
);
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] busy_nxt;

    // Set is applied after clear so a same-edge set wins; r0 is never tracked.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        busy_nxt    = (busy & ~clr_mask) | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between ALU and load writeback into a single register-file
// write port, with registered write outputs and a pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int n = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [n-1:0]          alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [n-1:0]          ld_data,
    output logic                  ld_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  regw,
    output logic [5:0]            waddr,
    output logic [n-1:0]          wdata
);
    grant_t                grant;
    logic                  prio_ld;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [n-1:0]          sel_data;
    logic                  regw_p1;
    logic [5:0]            waddr_p1;
    logic [n-1:0]          wdata_p1;

    // p0: grant decision, combinational from valids and the priority bit
    always_comb begin
        grant    = GNT_NONE;
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (!reset) begin
            if (alu_valid && ld_valid) grant = prio_ld ? GNT_LD : GNT_ALU;
            else if (alu_valid)        grant = GNT_ALU;
            else if (ld_valid)         grant = GNT_LD;
        end
        if (grant == GNT_LD) begin
            sel_addr = ld_addr;
            sel_data = ld_data;
        end
    end

    assign alu_ready = (grant == GNT_ALU);
    assign ld_ready  = (grant == GNT_LD);

    // p1: registered write port; any grant hands priority to the other side
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_ld  <= 1'b0;
            regw_p1  <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            regw_p1 <= (grant != GNT_NONE) && (sel_addr != '0);
            if ((grant != GNT_NONE) && (sel_addr != '0)) begin
                waddr_p1 <= {1'b0, sel_addr};
                wdata_p1 <= sel_data;
            end
            if (grant == GNT_ALU)     prio_ld <= 1'b1;
            else if (grant == GNT_LD) prio_ld <= 1'b0;
        end
    end

    assign regw  = regw_p1;
    assign waddr = waddr_p1;
    assign wdata = wdata_p1;

    wb_scoreboard u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_en  (issue_valid && (issue_rd != '0)),
        .set_idx (issue_rd),
        .clr_en  (regw_p1),
        .clr_idx (waddr_p1[REG_ADDR_W-1:0]),
        .busy    (busy)
    );
endmodule
